// File: rtl/cpu_defs.sv
// Shared definitions for the execute-stage divider: state encoding,
// iteration count and HI/LO field positions inside the packed result.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BY_ZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } div_state_e;

    localparam int unsigned DIV_CYCLES = 32;

    // Field index within result; multiply by WIDTH for the bit offset.
    localparam int unsigned LO_FIELD = 0;
    localparam int unsigned HI_FIELD = 1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and
// subtract the divisor from the partial remainder when it fits.
module div_step
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        // rem < divisor holds between steps, so the top bit is a clean borrow.
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU in the execute stage,
// producing {HI=remainder, LO=quotient} and the long-stall request.
module div_unit
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               stall,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   dividend_abs, divisor_abs;
    logic               dividend_neg, divisor_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        dividend_neg = signed_div & opdata1[WIDTH-1];
        divisor_neg  = signed_div & opdata2[WIDTH-1];
        dividend_abs = dividend_neg ? -opdata1 : opdata1;
        divisor_abs  = divisor_neg  ? -opdata2 : opdata2;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        ready = (state_q == END) & ~annul;
        stall = start & ~ready & ~annul;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d   = ON;
                        counter_d = '0;
                        rem_d     = '0;
                        quo_d     = dividend_abs;
                        divisor_d = divisor_abs;
                        neg_quo_d = dividend_neg ^ divisor_neg;
                        neg_rem_d = dividend_neg;
                    end
                end
            end
            BY_ZERO: begin
                state_d  = END;
                result_d = '0;
            end
            ON: begin
                rem_d     = step_rem;
                quo_d     = step_quo;
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = END;
                    counter_d = '0;
                    // Sign fix-up folded into the final step's register load.
                    result_d[HI_FIELD*WIDTH +: WIDTH] = neg_rem_q ? -step_rem : step_rem;
                    result_d[LO_FIELD*WIDTH +: WIDTH] = neg_quo_q ? -step_quo : step_quo;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (annul) begin
            state_d   = IDLE;
            counter_d = '0;
            result_d  = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

    // The instruction must stay in E until the divide finishes or is flushed.
    start_held_a: assert property (@(posedge clk) disable iff (!resetn)
        ((state_q == ON || state_q == BY_ZERO) && !annul) |-> start);

endmodule
